// File: rtl/inst_loader.sv
// Streams received bytes into instruction memory while holding the PC in reset,
// ending on a word-aligned HALT (done) or on filling the whole memory (overflow).
module inst_loader #(
    parameter int                          MEM_SIZE         = 8,
    parameter int                          INSTMEM_SIZE     = 8,
    parameter int                          INSTRUCTION_SIZE = 32,
    parameter logic [INSTRUCTION_SIZE-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MEM_SIZE-1:0]     i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_write_enable,
    output logic [MEM_SIZE-1:0]     o_write_data,
    output logic [INSTMEM_SIZE-1:0] o_write_addr,
    output logic                    o_instru_mem_enable,
    output logic                    o_pc_reset,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overflow,
    output logic [INSTMEM_SIZE-2:0] o_inst_count
);

    localparam int BYTES_PER_WORD = INSTRUCTION_SIZE / MEM_SIZE;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam logic [INSTMEM_SIZE-1:0] PTR_ONE = 1;
    localparam logic [INSTMEM_SIZE-2:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t                        state_q;
    logic [INSTMEM_SIZE-1:0]       ptr_q;
    logic [INSTRUCTION_SIZE-1:0]   word_q;
    logic [INSTRUCTION_SIZE-1:0]   word_d;
    logic [INSTMEM_SIZE-2:0]       count_q;
    logic [INSTMEM_SIZE-2:0]       count_d;
    logic                          we_q;
    logic [MEM_SIZE-1:0]           wdata_q;
    logic [INSTMEM_SIZE-1:0]       waddr_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          ovf_q;
    logic                          word_end;
    logic                          last_byte;
    logic                          halt_hit;

    // Big-endian word assembly: the first byte of a word ends up in the MSB.
    always_comb begin
        word_d    = {word_q[INSTRUCTION_SIZE-MEM_SIZE-1:0], i_rx_data};
        word_end  = &ptr_q[LANE_W-1:0];
        last_byte = &ptr_q;
        halt_hit  = word_end && (word_d == HALT_INSTRUCTION);
        count_d   = word_end ? (count_q + CNT_ONE) : count_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                        word_q  <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (i_rx_valid) begin
                        we_q    <= 1'b1;
                        wdata_q <= i_rx_data;
                        waddr_q <= ptr_q;
                        word_q  <= word_d;
                        count_q <= count_d;
                        // Pointer saturates at the top; the load ends there anyway.
                        if (!last_byte) begin
                            ptr_q <= ptr_q + PTR_ONE;
                        end
                        if (halt_hit) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (last_byte) begin
                            state_q <= ERROR;
                            ovf_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_write_enable      = we_q;
    assign o_write_data        = wdata_q;
    assign o_write_addr        = waddr_q;
    assign o_busy              = busy_q;
    assign o_pc_reset          = busy_q;
    assign o_instru_mem_enable = busy_q;
    assign o_done              = done_q;
    assign o_overflow          = ovf_q;
    assign o_inst_count        = count_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

- Sits directly upstream of the instruction-fetch stage.
- Takes a byte stream from the debug/UART receive path and writes it into instruction memory as byte-wide, address-incrementing writes.
- Holds the program counter in reset while loading, detects the word-aligned HALT instruction that ends the program, and reports done or overflow.
- Its outputs connect straight to the fetch stage's instruction-memory write port and PC reset.

## Interface

Parameters:
- MEM_SIZE, 8, width of one memory write (byte).
- INSTMEM_SIZE, 8, instruction-memory byte address width (256 bytes).
- INSTRUCTION_SIZE, 32, instruction width (4 bytes per word).
- HALT_INSTRUCTION, 32'hFFFFFFFF, end-of-program marker.

Ports. One clock; reset is synchronous and active-high.
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous active-high reset.
- i_start  input  1  one-cycle pulse; begins a new load from address 0.
- i_rx_data  input  MEM_SIZE  received byte.
- i_rx_valid  input  1  i_rx_data valid this cycle (single-cycle strobe per byte).
- o_write_enable  output  1  instruction-memory write strobe.
- o_write_data  output  MEM_SIZE  byte to write.
- o_write_addr  output  INSTMEM_SIZE  byte address to write.
- o_instru_mem_enable  output  1  memory enable; high while in LOAD.
- o_pc_reset  output  1  PC reset; high while in LOAD.
- o_busy  output  1  high in LOAD.
- o_done  output  1  HALT written; sticky.
- o_overflow  output  1  memory filled without HALT; sticky.
- o_inst_count  output  INSTMEM_SIZE-1  complete words written in the current load.

## Operation

States: IDLE, LOAD, DONE, ERROR. Reset enters IDLE.

- **IDLE**
  - i_rx_valid is ignored.
  - i_start moves the FSM to LOAD and clears the pointer, word shift register and o_inst_count.
- **LOAD**, on each i_rx_valid:
  - Write o_write_data = i_rx_data and o_write_addr = pointer.
  - Increment the pointer.
  - Shift the byte into the 32-bit word register big-endian: word = {word[23:0], byte}, so the first byte is the MSB.
  - i_start is ignored in LOAD.
- **Word completion**
  - A word completes when the accepted byte's address has bits [1:0] == 2'b11.
  - On completion, o_inst_count increments.
  - If the completed word equals HALT_INSTRUCTION, go to DONE.
  - HALT is detected only on word-aligned words. FF bytes straddling a word boundary do not terminate the load.
- **Overflow**: when the byte at address 2^INSTMEM_SIZE-1 is accepted and it does not complete a HALT word, go to ERROR. HALT at the last word takes precedence and goes to DONE.
  - The pointer never wraps.
  - No write is issued after address 2^INSTMEM_SIZE-1.
- **DONE / ERROR**
  - o_done or o_overflow is held high; i_rx_valid is ignored.
  - i_start clears both flags and restarts LOAD from address 0.
  - i_reset returns the FSM to IDLE.
- **Reset mid-load**
  - Next cycle: IDLE, all outputs 0, pointer 0.
  - Memory contents already written are not cleared.
  - A pending write strobe is dropped.
- **i_start with i_rx_valid in the same IDLE cycle**: the byte is discarded. The first accepted byte is the next valid.

## Timing

- All outputs are registered.
- Reset values: every output 0, o_write_addr 0, o_inst_count 0.
- Write latency:
  - o_write_enable is high for exactly one cycle, the cycle after i_rx_valid is sampled in LOAD.
  - o_write_data and o_write_addr are valid in that same cycle.
- Back-to-back i_rx_valid on consecutive cycles produces consecutive write strobes with addresses n, n+1. Throughput is 1 byte/cycle.
- State outputs: o_busy, o_pc_reset and o_instru_mem_enable go high the cycle after i_start is sampled in IDLE.
- Termination:
  - o_done or o_overflow rises in the same cycle as the final byte's write strobe.
  - In that cycle, o_busy and o_pc_reset fall, and o_inst_count shows the final count.
  - The final write is still performed, so the HALT word is stored in memory.

## Test plan

- **Normal load**: reset, i_start, then 12 bytes 20 01 00 05 / 20 02 00 07 / FF FF FF FF.
  - Writes at addresses 0..11 with matching data, one cycle after each valid.
  - o_done rises with the write to address 11; o_inst_count = 3; o_pc_reset low afterwards.
- **Misaligned FF**: bytes 00 00 FF FF FF FF 00 00, then FF FF FF FF.
  - No DONE after byte 6.
  - DONE after byte 12; o_inst_count = 3.
- **Overflow**: 256 bytes of 0x00 at 1 byte/cycle.
  - Writes at addresses 0..255; o_overflow rises with the address-255 write.
  - No write strobe for a 257th byte; o_inst_count = 64 (wraps to 0 only if the width is too small; must read 64 with INSTMEM_SIZE-1 = 7 bits).
- **Reset mid-load**: i_reset asserted after 5 bytes.
  - Next cycle: IDLE, all outputs 0.
  - A following i_start plus 4 bytes FF FF FF FF gives writes at 0..3 and o_done.
- **Start/valid collision**: i_start and i_rx_valid (0xAA) in the same cycle.
  - 0xAA is not written.
  - The next byte 0xBB is written to address 0.
- **Restart after done/overflow**: i_start in DONE.
  - o_done clears and o_busy rises the next cycle.
  - The new load begins at address 0 with o_inst_count = 0.
